// File: rtl/ulbf_coeffs_stream_reader.sv
// ============================================================================
// ulbf_coeffs_stream_reader : coefficient RAM port-B reader -> AXI4-Stream master
// Rev 1.0
// ============================================================================
`default_nettype none

module ulbf_coeffs_stream_reader #(
  parameter int DATA_WIDTH       = 64,
  parameter int RAM_DEPTH        = 4096,
  parameter int RAM_READ_LATENCY = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           cfg_base_addr,
  input  logic [15:0]           cfg_len,
  input  logic [15:0]           cfg_nframes,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [15:0]           addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int          LAT       = RAM_READ_LATENCY;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 2;
  localparam logic [15:0] ADDR_MASK = 16'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     base_q, base_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     nframes_q, nframes_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            stop_seen_q, stop_seen_d;
  logic            zero_done_q, zero_done_d;
  logic [LAT-1:0]  pv_q, pv_d;
  logic [LAT-1:0]  pl_q, pl_d;
  logic [CW-1:0]   pipe_cnt_q, pipe_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];

  logic issue;
  logic is_last;
  logic push;
  logic pop;
  logic fifo_empty;
  logic drain_done;

  // Credit check: every word in flight already owns a FIFO slot.
  assign fifo_empty = (fifo_cnt_q == '0);
  assign issue      = (state_q == S_RUN) && ((pipe_cnt_q + fifo_cnt_q) < CW'(FIFO_DEPTH));
  assign is_last    = (word_idx_q == (len_q - 16'd1));
  assign push       = pv_q[LAT-1];
  assign pop        = !fifo_empty && m_axis_tready;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    nframes_d   = nframes_q;
    word_idx_d  = word_idx_q;
    frame_cnt_d = frame_cnt_q;
    stop_seen_d = stop_seen_q;
    zero_done_d = 1'b0;
    drain_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = cfg_base_addr;
          len_d       = cfg_len;
          nframes_d   = cfg_nframes;
          word_idx_d  = 16'd0;
          frame_cnt_d = 16'd0;
          stop_seen_d = 1'b0;
          if (cfg_len != 16'd0) begin
            state_d = S_RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        stop_seen_d = stop_seen_q | stop;
        if (issue) begin
          if (is_last) begin
            word_idx_d  = 16'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (((nframes_q != 16'd0) && ((frame_cnt_q + 16'd1) == nframes_q)) ||
                stop_seen_q || stop) begin
              state_d     = S_DRAIN;
              stop_seen_d = 1'b0;
            end
          end else begin
            word_idx_d = word_idx_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if ((pipe_cnt_q == '0) && fifo_empty) begin
          state_d    = S_IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read pipeline shadow and FIFO bookkeeping.
  always_comb begin
    pv_d    = '0;
    pl_d    = '0;
    pv_d[0] = issue;
    pl_d[0] = issue && is_last;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
    pipe_cnt_d = pipe_cnt_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, push};
    fifo_cnt_d = fifo_cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state_q     <= S_IDLE;
      base_q      <= 16'd0;
      len_q       <= 16'd0;
      nframes_q   <= 16'd0;
      word_idx_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
      stop_seen_q <= 1'b0;
      zero_done_q <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      pipe_cnt_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      nframes_q   <= nframes_d;
      word_idx_q  <= word_idx_d;
      frame_cnt_q <= frame_cnt_d;
      stop_seen_q <= stop_seen_d;
      zero_done_q <= zero_done_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      pipe_cnt_q  <= pipe_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge m_axis_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= doutb;
      fifo_last_q[wr_ptr_q] <= pl_q[LAT-1];
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = zero_done_q | drain_done;
  assign enb           = issue;
  assign addrb         = issue ? ((base_q + word_idx_q) & ADDR_MASK) : 16'd0;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_last_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_ulbf_coeffs_stream_reader.sv
// ============================================================================
// tb_ulbf_coeffs_stream_reader : directed bench with latency-4 RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ulbf_coeffs_stream_reader;

  logic        m_axis_clk = 1'b0;
  logic        m_axis_rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_base_addr = '0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_nframes = '0;
  logic        busy, done, enb;
  logic [15:0] addrb;
  logic [63:0] doutb;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;

  ulbf_coeffs_stream_reader #(
    .DATA_WIDTH(64), .RAM_DEPTH(4096), .RAM_READ_LATENCY(4), .FIFO_DEPTH(8)
  ) dut (
    .m_axis_clk(m_axis_clk), .m_axis_rst(m_axis_rst), .start(start), .stop(stop),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_nframes(cfg_nframes),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .doutb(doutb),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 m_axis_clk = ~m_axis_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ram_word(input int a);
    return {32'hC0EF_0000 | 32'(a), ~32'(a)};
  endfunction

  // Latency-4 RAM: address sampled on enb, data appears four cycles later.
  logic [63:0] ram [4096];
  logic [63:0] rstage [4];
  always @(posedge m_axis_clk) begin
    rstage[0] <= enb ? ram[addrb[11:0]] : 64'hDEAD_DEAD_DEAD_DEAD;
    for (int k = 1; k < 4; k++) rstage[k] <= rstage[k-1];
  end
  assign doutb = rstage[3];

  int cyc = 0;
  int cyc0 = 0;
  bit active = 1'b0;
  int tr_mode = 0;
  int stop_rel = -1;
  always @(posedge m_axis_clk) cyc <= cyc + 1;

  int drv_rel;
  always @(posedge m_axis_clk) begin
    #2;
    if (active) begin
      drv_rel = cyc - cyc0;
      stop = (drv_rel == stop_rel);
      case (tr_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (drv_rel % 2 == 0);
        default: m_axis_tready = (drv_rel > 20);
      endcase
    end else begin
      stop = 1'b0;
      m_axis_tready = 1'b1;
    end
  end

  logic [63:0] bdata [$];
  bit          blast [$];
  int          bcyc [$];
  logic [15:0] iaddr [$];
  int          icyc [$];
  int done_cnt, done_cyc, first_valid, occ_viol, stab_viol, outst, busy_cnt;
  bit          prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;
  int          mon_rel;

  task automatic clear_log();
    bdata.delete(); blast.delete(); bcyc.delete(); iaddr.delete(); icyc.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; occ_viol = 0; stab_viol = 0;
    outst = 0; busy_cnt = 0; prev_stall = 1'b0;
  endtask

  // Outstanding = issued minus popped in earlier cycles, i.e. pipe + FIFO.
  always @(negedge m_axis_clk) begin
    if (active) begin
      mon_rel = cyc - cyc0;
      if (enb) begin
        iaddr.push_back(addrb);
        icyc.push_back(mon_rel);
        if (outst >= 8) occ_viol++;
        outst++;
      end
      if (prev_stall && (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)) stab_viol++;
      if (m_axis_tvalid && first_valid < 0) first_valid = mon_rel;
      if (m_axis_tvalid && m_axis_tready) begin
        bdata.push_back(m_axis_tdata);
        blast.push_back(m_axis_tlast);
        bcyc.push_back(mon_rel);
        outst--;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = mon_rel;
      end
    end
  end

  task automatic kick(input logic [15:0] base, input logic [15:0] len, input logic [15:0] nf,
                      input int mode, input int stop_at);
    clear_log();
    cfg_base_addr = base; cfg_len = len; cfg_nframes = nf;
    tr_mode = mode; stop_rel = stop_at;
    @(posedge m_axis_clk); #1;
    cyc0 = cyc; active = 1'b1; start = 1'b1;
    @(posedge m_axis_clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] base, input logic [15:0] len, input logic [15:0] nf,
                     input int mode, input int stop_at, input int budget);
    kick(base, len, nf, mode, stop_at);
    while (done_cnt == 0 && (cyc - cyc0) < budget) @(posedge m_axis_clk);
    if (done_cnt == 0) check_value("done_timeout", 64'(done_cnt), 64'd1);
    repeat (4) @(posedge m_axis_clk);
    #1 active = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int base, input int len, input int n);
    check_value({tag, "_nbeats"}, 64'(bdata.size()), 64'(n));
    for (int i = 0; i < n && i < bdata.size(); i++) begin
      check_value($sformatf("%s_data%0d", tag, i), bdata[i], ram_word((base + (i % len)) % 4096));
      check_value($sformatf("%s_last%0d", tag, i), 64'(blast[i]), 64'((i % len) == len - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = ram_word(i);
    repeat (3) @(posedge m_axis_clk);
    #1;
    check_value("rst_busy", 64'(busy), 0);
    check_value("rst_enb", 64'(enb), 0);
    check_value("rst_tvalid", 64'(m_axis_tvalid), 0);
    check_value("rst_tdata", m_axis_tdata, 0);
    m_axis_rst = 1'b0;
    #1;
    check_value("idle_done", 64'(done), 0);
    check_value("idle_addrb", 64'(addrb), 0);
    check_value("idle_tlast", 64'(m_axis_tlast), 0);

    // T1: single frame, full throughput, latency and done timing
    run(16'h0010, 16'd4, 16'd1, 0, -1, 100);
    check_value("t1_nissue", 64'(iaddr.size()), 4);
    for (int i = 0; i < 4 && i < iaddr.size(); i++) begin
      check_value($sformatf("t1_addr%0d", i), 64'(iaddr[i]), 64'(16 + i));
      check_value($sformatf("t1_icyc%0d", i), 64'(icyc[i]), 64'(i + 1));
    end
    check_value("t1_first_valid", 64'(first_valid), 6);
    check_beats("t1", 16, 4, 4);
    if (bcyc.size() == 4) check_value("t1_last_pop_cyc", 64'(bcyc[3]), 9);
    check_value("t1_done_cyc", 64'(done_cyc), 10);
    check_value("t1_done_cnt", 64'(done_cnt), 1);

    // T2: two frames with toggling ready
    run(16'h0200, 16'd3, 16'd2, 1, -1, 200);
    check_beats("t2", 'h200, 3, 6);
    check_value("t2_occ", 64'(occ_viol), 0);
    check_value("t2_stable", 64'(stab_viol), 0);
    check_value("t2_done_cnt", 64'(done_cnt), 1);

    // T3: address wrap inside a frame
    run(16'd4094, 16'd4, 16'd1, 0, -1, 100);
    check_value("t3_nissue", 64'(iaddr.size()), 4);
    if (iaddr.size() == 4) begin
      check_value("t3_a0", 64'(iaddr[0]), 4094);
      check_value("t3_a1", 64'(iaddr[1]), 4095);
      check_value("t3_a2", 64'(iaddr[2]), 0);
      check_value("t3_a3", 64'(iaddr[3]), 1);
    end
    check_beats("t3", 4094, 4, 4);

    // T4: continuous mode, stop during frame 3
    run(16'h0300, 16'd5, 16'd0, 0, 12, 200);
    check_beats("t4", 'h300, 5, 15);
    check_value("t4_done_cnt", 64'(done_cnt), 1);

    // T5: ready held low for 20 cycles
    run(16'h0400, 16'd12, 16'd1, 2, -1, 300);
    begin
      int early = 0;
      for (int i = 0; i < icyc.size(); i++) if (icyc[i] <= 20) early++;
      check_value("t5_issues_stalled", 64'(early), 8);
    end
    check_value("t5_occ", 64'(occ_viol), 0);
    check_value("t5_stable", 64'(stab_viol), 0);
    check_beats("t5", 'h400, 12, 12);

    // Zero-length start
    run(16'h0010, 16'd0, 16'd1, 0, -1, 20);
    check_value("z_done_cyc", 64'(done_cyc), 1);
    check_value("z_nissue", 64'(iaddr.size()), 0);
    check_value("z_busy", 64'(busy_cnt), 0);
    check_value("z_done_cnt", 64'(done_cnt), 1);

    // T6: reset with three reads in flight, then clean restart
    kick(16'h0500, 16'd10, 16'd1, 0, -1);
    repeat (3) @(posedge m_axis_clk);
    #1;
    check_value("t6_inflight", 64'(iaddr.size()), 3);
    m_axis_rst = 1'b1;
    #1;
    check_value("t6_enb", 64'(enb), 0);
    check_value("t6_busy", 64'(busy), 0);
    check_value("t6_addrb", 64'(addrb), 0);
    check_value("t6_tvalid", 64'(m_axis_tvalid), 0);
    check_value("t6_tdata", m_axis_tdata, 0);
    active = 1'b0;
    repeat (2) @(posedge m_axis_clk);
    #1 m_axis_rst = 1'b0;
    run(16'h0500, 16'd4, 16'd1, 0, -1, 100);
    check_value("t6_first_valid", 64'(first_valid), 6);
    check_beats("t6", 'h500, 4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
